prbs_checker: RTL
=================

Name: prbs_checker

Overview:
- Serial receiver and checker for the 8-bit XNOR LFSR stream (taps [7],[6], newest bit in [0]) that the existing `lfsr` generator emits.
- Self-synchronises to the incoming bit stream, declares lock, then flywheels its own sequence and counts bit errors.
- Sits at the far end of a link or loopback fed by `lfsr.out` and `lfsr.en`.
- Used for link bring-up and BER measurement.

Parameters:
- LOCK_COUNT, 8: consecutive correct predictions in SEARCH required to enter LOCKED (1..255).
- UNLOCK_ERRS, 4: consecutive mispredictions in LOCKED that force resync (1..255).
- CNT_W, 16: width of err_count and bit_count.

Ports:
- clk  input  1  clock; all state updates on posedge.
- rst  input  1  reset; synchronous, active-high.
- en  input  1  din is valid this cycle; mirrors generator en.
- din  input  1  received serial bit.
- clr_cnt  input  1  synchronously zero err_count and bit_count; lock state unaffected.
- locked  output  1  registered; 1 while in LOCKED.
- err_pulse  output  1  registered one-cycle strobe per mismatched bit while LOCKED.
- err_count  output  CNT_W  saturating count of mismatches while LOCKED.
- bit_count  output  CNT_W  saturating count of bits checked while LOCKED.

Behaviour:
- Reset state:
  - state=FILL; shreg=0, fill_cnt=0, run_cnt=0, bad_cnt=0.
  - locked=0, err_pulse=0, err_count=0, bit_count=0.
- rst has priority over everything, including mid-lock; a frame in progress is abandoned.
- en=0: no register changes, except err_pulse, which returns to 0.
- exp = ~(shreg[7] ^ shreg[6]); this is identical to the generator's next bit.
- FILL, on en:
  - shreg <= {shreg[6:0], din}; fill_cnt++.
  - When fill_cnt==7: go to SEARCH, fill_cnt <= 0, run_cnt <= 0.
- SEARCH, on en:
  - shreg <= {shreg[6:0], din}.
  - match = (din==exp) && (shreg != 8'hFF). The all-ones lockup state never qualifies.
  - match: run_cnt++. If run_cnt==LOCK_COUNT-1, go to LOCKED, run_cnt <= 0, bad_cnt <= 0.
  - No match: run_cnt <= 0.
  - No counting in SEARCH.
- LOCKED, on en:
  - shreg <= {shreg[6:0], exp} (flywheel). Received errors never enter the predictor.
  - bit_count++ (saturating at all-ones).
  - din != exp: err_pulse=1 next cycle; err_count++ (saturating); bad_cnt++.
  - If bad_cnt==UNLOCK_ERRS-1 on a mismatch: go to FILL, fill_cnt <= 0, bad_cnt <= 0.
  - din == exp: bad_cnt <= 0.
- locked is the registered state decode.
  - Rises the cycle after the LOCK_COUNT-th qualifying bit.
  - Falls the cycle after the unlocking bit.
- err_pulse latency: 1 cycle after the en cycle carrying the bad bit.
- clr_cnt in the same cycle as a counted event: result is 0 + event.
  - Example: clr_cnt with a mismatch gives err_count=1 and bit_count=1.
- Counters hold their value across unlock/relock. Only rst or clr_cnt zero them.
- Minimum time to lock from reset with en every cycle: 8 fill + LOCK_COUNT bits.
  - With defaults: locked=1 in the cycle after the 16th enabled bit.

Decomposition:
- Package prbs_pkg holds:
  - LFSR_W=8, TAP_HI=7, TAP_LO=6.
  - Enum state_t {FILL, SEARCH, LOCKED}.
  - Function prbs_next(logic [7:0]) returning ~(s[7]^s[6]).
- The generator and this checker both reference prbs_next, so the polynomial is defined once.
- Sub-module optional: prbs_sat_counter (parameterised width, inc, clr, saturating), instantiated twice.
- The FSM stays in prbs_checker.

Test Plan:
- Lock acquisition:
  - Stimulus: reset `lfsr` and checker together, en=1 every cycle, din=lfsr.out.
  - Response: locked=0 through bit 16 and 1 from the next cycle; err_count=0 and bit_count increments per bit thereafter.
- All-ones lockup:
  - Stimulus: din=1 constant, en=1 for 100 cycles.
  - Response: locked stays 0, counters stay 0.
- Single flip:
  - Stimulus: after lock, invert one bit.
  - Response: err_pulse high exactly 1 cycle (next cycle), err_count=1, locked stays 1. No follow-on errors, because of the flywheel.
- Unlock and relock:
  - Stimulus: after lock, invert 4 consecutive bits, then resume clean stream.
  - Response: err_count=4; locked drops after the 4th flip; relocks 16 enabled bits later; err_count still 4.
- Gaps and clear:
  - Stimulus: toggle en pseudo-randomly with the generator.
  - Response: lock and bit_count track only en cycles.
  - Stimulus: pulse clr_cnt coincident with a flipped bit.
  - Response: err_count=1, bit_count=1.
- Reset mid-lock and saturation:
  - Stimulus: assert rst while locked with counters nonzero.
  - Response: next cycle all outputs 0, state FILL.
  - Stimulus: with CNT_W=4, inject 20 errors spaced more than UNLOCK_ERRS bits apart.
  - Response: err_count holds at 15.

Source files
------------

// File: rtl/prbs_pkg.sv
// prbs_pkg: shared PRBS-8 XNOR polynomial, FSM states and predictor function
package prbs_pkg;
  localparam int LFSR_W = 8;
  localparam int TAP_HI = 7;
  localparam int TAP_LO = 6;
  typedef enum logic [1:0] {FILL, SEARCH, LOCKED} state_t;
  function automatic logic prbs_next(input logic [LFSR_W-1:0] s);
    return ~(s[TAP_HI] ^ s[TAP_LO]);
  endfunction
endpackage

// File: rtl/prbs_sat_counter.sv
// prbs_sat_counter: saturating up-counter; clr and inc together yields 1
module prbs_sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] q
);
  logic [W-1:0] base;
  assign base = clr ? '0 : q;
  always_ff @(posedge clk)
    if (rst) q <= '0;
    else q <= base + {{(W-1){1'b0}}, inc & ~&base};
endmodule

// File: rtl/prbs_checker.sv
// prbs_checker: self-synchronising PRBS-8 receiver with flywheel prediction and BER counters
module prbs_checker
  import prbs_pkg::*;
#(
  parameter int LOCK_COUNT  = 8,
  parameter int UNLOCK_ERRS = 4,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             din,
  input  logic             clr_cnt,
  output logic             locked,
  output logic             err_pulse,
  output logic [CNT_W-1:0] err_count,
  output logic [CNT_W-1:0] bit_count
);
  state_t state, state_d;
  logic [LFSR_W-1:0] shreg, shreg_d;
  logic [2:0] fill_cnt, fill_d;
  logic [7:0] run_cnt, run_d, bad_cnt, bad_d;
  logic exp_bit, mis, ep_d, err_inc, bit_inc;
  assign exp_bit = prbs_next(shreg);
  assign mis = din != exp_bit;
  always_comb begin
    state_d = state;
    shreg_d = shreg;
    fill_d = fill_cnt;
    run_d = run_cnt;
    bad_d = bad_cnt;
    ep_d = 1'b0;
    err_inc = 1'b0;
    bit_inc = 1'b0;
    if (en)
      case (state)
        FILL: begin
          shreg_d = {shreg[LFSR_W-2:0], din};
          fill_d = fill_cnt + 3'd1;
          if (fill_cnt == 3'd7) begin
            state_d = SEARCH;
            fill_d = '0;
            run_d = '0;
          end
        end
        SEARCH: begin
          shreg_d = {shreg[LFSR_W-2:0], din};
          run_d = '0;
          // all-ones is the XNOR lockup state and never counts toward lock
          if (!mis && shreg != '1) begin
            run_d = run_cnt + 8'd1;
            if (run_cnt == 8'(LOCK_COUNT - 1)) begin
              state_d = LOCKED;
              run_d = '0;
              bad_d = '0;
            end
          end
        end
        LOCKED: begin
          shreg_d = {shreg[LFSR_W-2:0], exp_bit};
          bit_inc = 1'b1;
          bad_d = '0;
          if (mis) begin
            ep_d = 1'b1;
            err_inc = 1'b1;
            bad_d = bad_cnt + 8'd1;
            if (bad_cnt == 8'(UNLOCK_ERRS - 1)) begin
              state_d = FILL;
              fill_d = '0;
              bad_d = '0;
            end
          end
        end
        default: state_d = FILL;
      endcase
  end
  always_ff @(posedge clk)
    if (rst) begin
      state <= FILL;
      shreg <= '0;
      fill_cnt <= '0;
      run_cnt <= '0;
      bad_cnt <= '0;
      locked <= 1'b0;
      err_pulse <= 1'b0;
    end else begin
      state <= state_d;
      shreg <= shreg_d;
      fill_cnt <= fill_d;
      run_cnt <= run_d;
      bad_cnt <= bad_d;
      locked <= state_d == LOCKED;
      err_pulse <= ep_d;
    end
  prbs_sat_counter #(.W(CNT_W)) u_err_cnt (
    .clk(clk), .rst(rst), .clr(clr_cnt), .inc(err_inc), .q(err_count)
  );
  prbs_sat_counter #(.W(CNT_W)) u_bit_cnt (
    .clk(clk), .rst(rst), .clr(clr_cnt), .inc(bit_inc), .q(bit_count)
  );
endmodule
